// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-byte holding register and error pulses.
// Define UART_PARITY_EN for 8E1 frames with parity checking.
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bits, bits_n;
  logic [7:0] sh, sh_n;
  logic s1, rxs, expire, stop_hit, done, bad;
  assign expire   = cnt == CW'(1);
  assign stop_hit = state == STOP && expire;
  assign done     = stop_hit && rxs && !bad;
`ifdef UART_PARITY_EN
  logic bad_n;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bad        <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      bad        <= bad_n;
      parity_err <= stop_hit && bad;
    end
  end
`else
  assign bad        = 1'b0;
  assign parity_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      rxs   <= 1'b1;
      state <= IDLE;
      cnt   <= '0;
      bits  <= '0;
      sh    <= '0;
    end else begin
      s1    <= rx;
      rxs   <= s1;
      state <= state_n;
      cnt   <= cnt_n;
      bits  <= bits_n;
      sh    <= sh_n;
    end
  end
  // Counter expires at 1 so that reloading FULL spaces samples exactly CLKS_PER_BIT apart
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bits_n  = bits;
    sh_n    = sh;
`ifdef UART_PARITY_EN
    bad_n   = bad;
`endif
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          cnt_n   = HALF;
          bits_n  = '0;
`ifdef UART_PARITY_EN
          bad_n   = 1'b0;
`endif
        end
      end
      START: begin
        cnt_n = expire ? FULL : cnt - CW'(1);
        if (expire) state_n = rxs ? IDLE : DATA;
      end
      DATA: begin
        cnt_n = expire ? FULL : cnt - CW'(1);
        if (expire) begin
          sh_n   = {rxs, sh[7:1]};
          bits_n = bits + 3'd1;
`ifdef UART_PARITY_EN
          if (bits == 3'd7) state_n = PARITY;
`else
          if (bits == 3'd7) state_n = STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        cnt_n = expire ? FULL : cnt - CW'(1);
        if (expire) begin
          bad_n   = ^{sh, rxs};
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        cnt_n = expire ? FULL : cnt - CW'(1);
        if (expire) state_n = rxs ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: state_n = rxs ? IDLE : WAIT_IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_hit && !rxs;
      overrun   <= done && rx_valid && !rx_ready;
      if (done && (!rx_valid || rx_ready)) begin
        rx_data  <= sh;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scoreboard bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;
  localparam int C = 16;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, parity_err, overrun;
  int n_assert = 0, n_fail = 0;
  int cyc = 0, fall_cyc = 0, rise_cyc = -1;
  int n_valid = 0, n_ferr = 0, n_perr = 0, n_ovr = 0;
  logic valid_q = 1'b0;
  logic [7:0] sbq[$];
  logic [7:0] exp_b;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int stop_len);
    fall_cyc = cyc;
    rx = 1'b0;
    idle(C);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(C);
    end
    rx = stop;
    idle(stop_len);
    rx = 1'b1;
  endtask

  task automatic clear_counts();
    n_valid = 0; n_ferr = 0; n_perr = 0; n_ovr = 0; rise_cyc = -1;
  endtask

  // Monitor: pulse counters, rx_valid rise time, and scoreboard pop on each handshake
  always @(negedge clk) begin
    if (rx_valid && !valid_q) rise_cyc = cyc;
    valid_q = rx_valid;
    if (rx_valid) n_valid++;
    if (frame_err) n_ferr++;
    if (parity_err) n_perr++;
    if (overrun) n_ovr++;
    if (rx_valid && rx_ready) begin
      check("unexpected_byte", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        exp_b = sbq.pop_front();
        check("rx_data", 32'(rx_data), 32'(exp_b));
      end
    end
  end

  initial begin
    idle(4);
    check("reset_outputs", 32'({rx_data, rx_valid, frame_err, parity_err, overrun}), 32'd0);
    rst_n = 1'b1;
    idle(5);
    check("idle_after_reset", 32'({rx_valid, frame_err, parity_err, overrun}), 32'd0);

    clear_counts();
    sbq.push_back(8'hA5);
    send(8'hA5, 1'b1, C);
    idle(20);
    check("a5_latency", 32'(rise_cyc - fall_cyc), 32'd155);
    check("a5_valid_cycles", 32'(n_valid), 32'd1);
    check("a5_flags", 32'(n_ferr + n_perr + n_ovr), 32'd0);
    check("a5_sb_empty", 32'(sbq.size()), 32'd0);

    clear_counts();
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    check("glitch_valid", 32'(n_valid), 32'd0);
    check("glitch_flags", 32'(n_ferr + n_perr + n_ovr), 32'd0);

    clear_counts();
    sbq.push_back(8'h55);
    send(8'h3C, 1'b0, 2 * C);
    idle(4);
    send(8'h55, 1'b1, C);
    idle(20);
    check("ferr_pulses", 32'(n_ferr), 32'd1);
    check("ferr_valid_cycles", 32'(n_valid), 32'd1);
    check("ferr_data", 32'(rx_data), 32'h55);
    check("ferr_sb_empty", 32'(sbq.size()), 32'd0);

    clear_counts();
    rx_ready = 1'b0;
    sbq.push_back(8'h11);
    send(8'h11, 1'b1, C);
    send(8'h22, 1'b1, C);
    idle(20);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_data_held", 32'(rx_data), 32'h11);
    check("ovr_pulses", 32'(n_ovr), 32'd1);
    check("ovr_no_ferr", 32'(n_ferr), 32'd0);
    rx_ready = 1'b1;
    idle(2);
    check("ovr_valid_fell", 32'(rx_valid), 32'd0);
    check("ovr_sb_empty", 32'(sbq.size()), 32'd0);

    clear_counts();
    rx = 1'b0;
    idle(C);
    rx = 1'b1;
    idle(4 * C + 8);
    rst_n = 1'b0;
    idle(3);
    check("midframe_reset_outputs", 32'({rx_data, rx_valid, frame_err, parity_err, overrun}), 32'd0);
    rst_n = 1'b1;
    idle(4 * C);
    sbq.push_back(8'h0F);
    send(8'h0F, 1'b1, C);
    idle(20);
    check("rst_valid_cycles", 32'(n_valid), 32'd1);
    check("rst_data", 32'(rx_data), 32'h0F);
    check("rst_flags", 32'(n_ferr + n_perr + n_ovr), 32'd0);
    check("final_sb_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
